// File: rtl/regfile_pkg.sv
// Shared types for the multi-port register array.
// Error codes reported per read port plus address-width helper.
package regfile_pkg;

    localparam int ERR_W = 2;

    typedef enum logic [ERR_W-1:0] {
        ERR_OK        = 2'd0,
        ERR_UNWRITTEN = 2'd1,
        ERR_OOR       = 2'd2,
        ERR_CONFLICT  = 2'd3
    } err_code_e;

    function automatic int addr_w(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/regfile_array_mp_if.sv
// Bus bundle for regfile_array_mp: write port, clear,
// packed read ports and error reporting.
interface regfile_array_mp_if
    import regfile_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int NUM_RD = 2,
    parameter int CNT_W  = 8
);
    localparam int AW   = addr_w(DEPTH);
    localparam int BE_W = DATA_W / 8;

    logic                       wr_en;
    logic [AW-1:0]              wr_addr;
    logic [DATA_W-1:0]          wr_data;
    logic [BE_W-1:0]            wr_be;
    logic                       clr;
    logic [NUM_RD-1:0]          rd_en;
    logic [NUM_RD*AW-1:0]       rd_addr;
    logic [NUM_RD*DATA_W-1:0]   rd_data;
    logic [NUM_RD-1:0]          rd_valid;
    logic [NUM_RD*ERR_W-1:0]    rd_err_code;
    logic                       wr_err;
    logic [CNT_W-1:0]           err_cnt;

    modport master (
        output wr_en, wr_addr, wr_data, wr_be, clr,
        output rd_en, rd_addr,
        input  rd_data, rd_valid, rd_err_code,
        input  wr_err, err_cnt
    );

    modport slave (
        input  wr_en, wr_addr, wr_data, wr_be, clr,
        input  rd_en, rd_addr,
        output rd_data, rd_valid, rd_err_code,
        output wr_err, err_cnt
    );

endinterface

// File: rtl/regfile_rd_port.sv
// One registered read port: classifies the request and
// returns stored data or an error code one cycle later.
module regfile_rd_port
    import regfile_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 8,
    parameter int AW     = 3
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic                    en,
    input  logic [AW-1:0]           addr,
    input  logic [DEPTH*DATA_W-1:0] mem_flat,
    input  logic [DEPTH-1:0]        written,
    input  logic                    conflict,
    output logic [DATA_W-1:0]       rd_data,
    output logic                    rd_valid,
    output err_code_e               code,
    output err_code_e               code_nxt
);

    localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);

    logic              oor;
    logic              hit;
    logic [DATA_W-1:0] sel;

    assign oor = {1'b0, addr} >= DEPTH_V;

    // Explicit mux over valid entries keeps odd depths in range
    always_comb begin
        sel = '0;
        hit = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (AW'(k) == addr) begin
                sel = mem_flat[k*DATA_W +: DATA_W];
                hit = written[k];
            end
        end
    end

    always_comb begin
        code_nxt = ERR_OK;
        if (en) begin
            unique case (1'b1)
                oor:                        code_nxt = ERR_OOR;
                (!oor && conflict):         code_nxt = ERR_CONFLICT;
                (!oor && !conflict && !hit): code_nxt = ERR_UNWRITTEN;
                default:                    code_nxt = ERR_OK;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
            code     <= ERR_OK;
        end else begin
            rd_valid <= en && (code_nxt == ERR_OK);
            rd_data  <= (en && code_nxt == ERR_OK) ? sel : '0;
            code     <= code_nxt;
        end
    end

endmodule

// File: rtl/regfile_array_mp.sv
// DEPTH x DATA_W register array, byte-enabled write port,
// NUM_RD registered read ports, written flags, error counter.
module regfile_array_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W       = 8,
    parameter int DEPTH        = 8,
    parameter int NUM_RD       = 2,
    parameter int CONFLICT_ERR = 0,
    parameter int CNT_W        = 8
) (
    input logic               clk,
    input logic               resetn,
    regfile_array_mp_if.slave bus
);

    localparam int AW   = addr_w(DEPTH);
    localparam int BE_W = DATA_W / 8;
    localparam int SW   = CNT_W + 3;
    localparam logic [AW:0]   DEPTH_V = (AW+1)'(DEPTH);
    localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});

    logic [DATA_W-1:0]       mem [DEPTH];
    logic [DEPTH-1:0]        written;
    logic [DEPTH*DATA_W-1:0] mem_flat;
    logic                    wr_in_rng;
    logic                    wr_acc;
    logic                    wr_err_nxt;
    logic                    conflict;
    logic [DATA_W-1:0]       old_word;
    logic                    old_flag;
    logic [DATA_W-1:0]       new_word;
    logic [2:0]              inc;
    logic [SW-1:0]           sum;

    err_code_e         code_q [NUM_RD];
    err_code_e         code_n [NUM_RD];
    logic [DATA_W-1:0] data_q [NUM_RD];
    logic              valid_q [NUM_RD];

    assign wr_in_rng  = {1'b0, bus.wr_addr} < DEPTH_V;
    assign wr_acc     = bus.wr_en && wr_in_rng && (|bus.wr_be);
    assign wr_err_nxt = bus.wr_en && !wr_in_rng;
    assign conflict   = (CONFLICT_ERR != 0) && bus.wr_en;

    always_comb begin
        old_word = '0;
        old_flag = 1'b0;
        for (int k = 0; k < DEPTH; k++) begin
            if (AW'(k) == bus.wr_addr) begin
                old_word = mem[k];
                old_flag = written[k];
            end
        end
    end

    // A same-cycle clr counts as already applied, so zero-fill wins
    always_comb begin
        new_word = '0;
        for (int b = 0; b < BE_W; b++) begin
            if (bus.wr_be[b])
                new_word[b*8 +: 8] = bus.wr_data[b*8 +: 8];
            else if (old_flag && !bus.clr)
                new_word[b*8 +: 8] = old_word[b*8 +: 8];
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < DEPTH; k++) begin
            if (wr_acc && AW'(k) == bus.wr_addr)
                mem[k] <= new_word;
        end
    end

    always_comb begin
        mem_flat = '0;
        for (int k = 0; k < DEPTH; k++)
            mem_flat[k*DATA_W +: DATA_W] = mem[k];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            written <= '0;
        end else begin
            for (int k = 0; k < DEPTH; k++) begin
                if (wr_acc && AW'(k) == bus.wr_addr)
                    written[k] <= 1'b1;
                else if (bus.clr)
                    written[k] <= 1'b0;
            end
        end
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        regfile_rd_port #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .AW     (AW)
        ) u_port (
            .clk      (clk),
            .resetn   (resetn),
            .en       (bus.rd_en[i]),
            .addr     (bus.rd_addr[i*AW +: AW]),
            .mem_flat (mem_flat),
            .written  (written),
            .conflict (conflict),
            .rd_data  (data_q[i]),
            .rd_valid (valid_q[i]),
            .code     (code_q[i]),
            .code_nxt (code_n[i])
        );
    end

    always_comb begin
        bus.rd_data     = '0;
        bus.rd_valid    = '0;
        bus.rd_err_code = '0;
        for (int i = 0; i < NUM_RD; i++) begin
            bus.rd_data[i*DATA_W +: DATA_W]   = data_q[i];
            bus.rd_valid[i]                   = valid_q[i];
            bus.rd_err_code[i*ERR_W +: ERR_W] = code_q[i];
        end
    end

    // Count events landing in the same edge as their codes
    always_comb begin
        inc = {2'b00, wr_err_nxt};
        for (int i = 0; i < NUM_RD; i++)
            inc = inc + {2'b00, code_n[i] != ERR_OK};
        sum = SW'(bus.err_cnt) + SW'(inc);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            bus.wr_err  <= 1'b0;
            bus.err_cnt <= '0;
        end else begin
            bus.wr_err  <= wr_err_nxt;
            bus.err_cnt <= (sum > CNT_MAX) ? CNT_MAX[CNT_W-1:0]
                                           : sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_regfile_array_mp.sv
// Scoreboard bench: two configurations share one stimulus stream,
// a reference model predicts outputs, a monitor compares them.
module tb_regfile_array_mp;

    typedef struct packed {
        logic            wr_en;
        logic [2:0]      wr_addr;
        logic [31:0]     wr_data;
        logic [3:0]      wr_be;
        logic            clr;
        logic [1:0]      rd_en;
        logic [1:0][2:0] ra;
    } stim_t;

    typedef struct packed {
        logic [1:0][31:0] d;
        logic [1:0]       v;
        logic [1:0][1:0]  c;
        logic             werr;
        logic [7:0]       cnt;
    } exp_t;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    int   checks = 0;
    int   failures = 0;

    exp_t qa [$];
    exp_t qb [$];

    logic [31:0] mmem [2][8];
    logic        mflag [2][8];
    int          mcnt [2];

    always #5 clk = ~clk;

    regfile_array_mp_if #(.DATA_W(32), .DEPTH(5), .NUM_RD(2), .CNT_W(2)) bus_a ();
    regfile_array_mp_if #(.DATA_W(8), .DEPTH(8), .NUM_RD(1), .CNT_W(8)) bus_b ();

    regfile_array_mp #(
        .DATA_W(32), .DEPTH(5), .NUM_RD(2), .CONFLICT_ERR(0), .CNT_W(2)
    ) dut_a (
        .clk(clk), .resetn(resetn), .bus(bus_a)
    );

    regfile_array_mp #(
        .DATA_W(8), .DEPTH(8), .NUM_RD(1), .CONFLICT_ERR(1), .CNT_W(8)
    ) dut_b (
        .clk(clk), .resetn(resetn), .bus(bus_b)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    // Reference: error priority, byte-merge and saturating count
    task automatic model(input int id, input stim_t s, output exp_t e);
        int  dep  = (id == 0) ? 5 : 8;
        int  nb   = (id == 0) ? 4 : 1;
        int  nr   = (id == 0) ? 2 : 1;
        bit  ce   = (id == 1);
        int  cmax = (id == 0) ? 3 : 255;
        int  errs = 0;
        int  a;
        logic [3:0] be;
        e = '0;
        for (int p = 0; p < nr; p++) begin
            if (s.rd_en[p]) begin
                a = int'(s.ra[p]);
                if (a >= dep)          e.c[p] = 2'd2;
                else if (ce && s.wr_en) e.c[p] = 2'd3;
                else if (!mflag[id][a]) e.c[p] = 2'd1;
                else begin
                    e.v[p] = 1'b1;
                    e.d[p] = (nb == 4) ? mmem[id][a] : {24'h0, mmem[id][a][7:0]};
                end
                if (e.c[p] != 2'd0) errs++;
            end
        end
        e.werr = s.wr_en && (int'(s.wr_addr) >= dep);
        if (e.werr) errs++;
        mcnt[id] = (mcnt[id] + errs > cmax) ? cmax : mcnt[id] + errs;
        e.cnt = 8'(mcnt[id]);
        if (s.clr)
            for (int k = 0; k < 8; k++) mflag[id][k] = 1'b0;
        be = s.wr_be & ((nb == 4) ? 4'hF : 4'h1);
        a = int'(s.wr_addr);
        if (s.wr_en && a < dep && be != 4'h0) begin
            for (int b = 0; b < nb; b++) begin
                if (be[b])              mmem[id][a][b*8 +: 8] = s.wr_data[b*8 +: 8];
                else if (!mflag[id][a]) mmem[id][a][b*8 +: 8] = 8'h00;
            end
            mflag[id][a] = 1'b1;
        end
    endtask

    task automatic apply(input stim_t s);
        bus_a.wr_en   = s.wr_en;
        bus_a.wr_addr = s.wr_addr;
        bus_a.wr_data = s.wr_data;
        bus_a.wr_be   = s.wr_be;
        bus_a.clr     = s.clr;
        bus_a.rd_en   = s.rd_en;
        bus_a.rd_addr = {s.ra[1], s.ra[0]};
        bus_b.wr_en   = s.wr_en;
        bus_b.wr_addr = s.wr_addr;
        bus_b.wr_data = s.wr_data[7:0];
        bus_b.wr_be   = s.wr_be[0];
        bus_b.clr     = s.clr;
        bus_b.rd_en   = s.rd_en[0];
        bus_b.rd_addr = s.ra[0];
    endtask

    task automatic step(input stim_t s);
        exp_t ea;
        exp_t eb;
        @(negedge clk);
        apply(s);
        model(0, s, ea);
        model(1, s, eb);
        qa.push_back(ea);
        qb.push_back(eb);
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        apply('0);
        for (int id = 0; id < 2; id++) begin
            mcnt[id] = 0;
            for (int k = 0; k < 8; k++) mflag[id][k] = 1'b0;
        end
        repeat (2) @(negedge clk);
        resetn = 1'b1;
    endtask

    function automatic stim_t mk(input logic we, input logic [2:0] wa,
                                 input logic [31:0] wd, input logic [3:0] be,
                                 input logic cl, input logic [1:0] re,
                                 input logic [2:0] r0, input logic [2:0] r1);
        stim_t s;
        s.wr_en = we; s.wr_addr = wa; s.wr_data = wd; s.wr_be = be;
        s.clr = cl; s.rd_en = re; s.ra[0] = r0; s.ra[1] = r1;
        return s;
    endfunction

    // Monitor: zeros while in reset, otherwise pop and compare
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or negedge resetn);
            #1;
            if (!resetn) begin
                chk("rst_a_data", bus_a.rd_data[31:0] | bus_a.rd_data[63:32], 32'h0);
                chk("rst_a_flags", {28'h0, bus_a.rd_valid, bus_a.wr_err, bus_a.err_cnt == 2'd0}, 32'h1);
                chk("rst_a_code", 32'(bus_a.rd_err_code), 32'h0);
                chk("rst_b_all", {bus_b.rd_data, 6'h0, bus_b.rd_valid, bus_b.wr_err, bus_b.err_cnt, 6'h0, bus_b.rd_err_code}, 32'h0);
            end else begin
                if (qa.size() > 0) begin
                    e = qa.pop_front();
                    chk("a_data0", bus_a.rd_data[31:0], e.d[0]);
                    chk("a_data1", bus_a.rd_data[63:32], e.d[1]);
                    chk("a_valid", 32'(bus_a.rd_valid), 32'(e.v));
                    chk("a_code0", 32'(bus_a.rd_err_code[1:0]), 32'(e.c[0]));
                    chk("a_code1", 32'(bus_a.rd_err_code[3:2]), 32'(e.c[1]));
                    chk("a_wr_err", 32'(bus_a.wr_err), 32'(e.werr));
                    chk("a_err_cnt", 32'(bus_a.err_cnt), 32'(e.cnt));
                end
                if (qb.size() > 0) begin
                    e = qb.pop_front();
                    chk("b_data0", 32'(bus_b.rd_data), e.d[0]);
                    chk("b_valid", 32'(bus_b.rd_valid), 32'(e.v[0]));
                    chk("b_code0", 32'(bus_b.rd_err_code), 32'(e.c[0]));
                    chk("b_wr_err", 32'(bus_b.wr_err), 32'(e.werr));
                    chk("b_err_cnt", 32'(bus_b.err_cnt), 32'(e.cnt));
                end
            end
        end
    end

    initial begin
        stim_t s;
        apply('0);
        do_reset();
        step(mk(0, 0, 0, 0, 0, 2'b01, 3, 0));
        step(mk(1, 2, 32'hA5, 4'h1, 0, 2'b00, 0, 0));
        step(mk(0, 0, 0, 0, 0, 2'b11, 2, 2));
        step(mk(1, 4, 32'h11223344, 4'b0101, 0, 2'b00, 0, 0));
        step(mk(0, 0, 0, 0, 0, 2'b01, 4, 0));
        step(mk(1, 4, 32'hFFFFFFFF, 4'b1000, 0, 2'b00, 0, 0));
        step(mk(0, 0, 0, 0, 0, 2'b11, 4, 6));
        step(mk(1, 7, 32'h5A, 4'hF, 0, 2'b00, 0, 0));
        step(mk(1, 1, 32'h3C, 4'h1, 0, 2'b01, 1, 0));
        step(mk(0, 0, 0, 0, 0, 2'b11, 1, 1));
        step(mk(1, 0, 32'h10, 4'hF, 0, 2'b00, 0, 0));
        step(mk(1, 0, 32'h77, 4'hF, 0, 2'b01, 0, 0));
        step(mk(0, 0, 0, 0, 0, 2'b01, 0, 0));
        step(mk(1, 6, 32'h1, 4'h0, 0, 2'b00, 0, 0));
        step(mk(1, 3, 32'hCAFEBABE, 4'b0010, 1, 2'b00, 0, 0));
        step(mk(1, 5, 32'h99, 4'h1, 1, 2'b00, 0, 0));
        step(mk(0, 0, 0, 0, 0, 2'b11, 5, 2));
        step(mk(0, 0, 0, 0, 0, 2'b11, 3, 5));
        step(mk(0, 0, 0, 0, 0, 2'b00, 0, 0));
        do_reset();
        step(mk(0, 0, 0, 0, 0, 2'b11, 2, 0));
        for (int i = 0; i < 3; i++)
            step(mk(0, 0, 0, 0, 0, 2'b11, 6, 7));
        for (int i = 0; i < 400; i++) begin
            if (i == 200) do_reset();
            s.wr_en   = 1'($urandom_range(0, 1));
            s.wr_addr = 3'($urandom_range(0, 7));
            s.wr_data = $urandom;
            s.wr_be   = 4'($urandom_range(0, 15));
            s.clr     = ($urandom_range(0, 15) == 0);
            s.rd_en   = 2'($urandom_range(0, 3));
            s.ra[0]   = 3'($urandom_range(0, 7));
            s.ra[1]   = 3'($urandom_range(0, 7));
            step(s);
        end
        step('0);
        repeat (3) @(negedge clk);
        chk("drain_a", 32'(qa.size()), 32'h0);
        chk("drain_b", 32'(qb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
